csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of operands, CSR data and results; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port req_valid  input  1  CSR instruction offered.
REQ-005 SHALL have port req_ready  output  1  unit can accept an instruction.
REQ-006 SHALL have port req_funct3  input  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-007 SHALL have port req_addr  input  12  target CSR address.
REQ-008 SHALL have port req_rs1  input  5  rs1 index, or zimm for the I variants.
REQ-009 SHALL have port req_rs1_data  input  XLEN  rs1 register value.
REQ-010 SHALL have port req_rd  input  5  destination register index.
REQ-011 SHALL have port csr_ren / csr_raddr  output  1 / 12  CSR read strobe and address to the CSR file.
REQ-012 SHALL have port csr_rdata  input  XLEN  combinational read data from the CSR file.
REQ-013 SHALL have port csr_wen / csr_waddr / csr_wdata  output  1 / 12 / XLEN  CSR write strobe, address and data.
REQ-014 SHALL have port resp_valid  output  1  result available.
REQ-015 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-016 SHALL have port resp_rd / resp_data / resp_we  output  5 / XLEN / 1  register writeback index, value and enable.
REQ-017 SHALL have port resp_illegal  output  1  illegal-instruction flag for this result.

Function
REQ-018 SHALL implement the FSM IDLE -> READ -> WRITE -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-019 SHALL latch funct3, addr, rs1, rs1_data and rd on the clock edge where req_valid&&req_ready is true.
REQ-020 SHALL compute src = rs1_data for funct3[2]=0 and src = zero-extended rs1 for funct3[2]=1.
REQ-021 SHALL, in READ, drive csr_ren=1 and csr_raddr=addr and register csr_rdata as old, unless the op is RW/RWI with rd=0, in which case csr_ren=0 and old=0.
REQ-022 SHALL, in WRITE, drive csr_waddr=addr and set csr_wdata to src for RW, old|src for RS, and old&~src for RC.
REQ-023 SHALL assert csr_wen for exactly the one WRITE cycle, except for RS/RC/RSI/RCI with rs1=0, where csr_wen=0.
REQ-024 SHALL drive csr_wdata=0 whenever csr_wen=0, and csr_ren=0 outside READ.
REQ-025 SHALL, in RESP, hold resp_valid=1 with resp_data=old, resp_rd=rd and resp_we=(rd!=0), stable until resp_ready=1.
REQ-026 SHALL leave RESP for IDLE on the edge with resp_ready=1 and accept the next request no earlier than one cycle later.
REQ-027 SHALL give a latency of 3 cycles from the accepting edge to resp_valid=1 for a legal op.
REQ-028 SHALL treat funct3 000 or 100 as illegal: go IDLE -> RESP directly, with no csr_ren and no csr_wen, resp_illegal=1, resp_we=0 and resp_data=0.
REQ-029 SHALL keep resp_illegal=0 for every legal op.

Reset
REQ-030 SHALL, while rst=0, force state IDLE and drive all outputs to 0 except req_ready=1, asynchronously.
REQ-031 SHALL, when reset is asserted mid-operation, abort the operation with no csr_wen and no resp_valid pulse after the assertion.
REQ-032 SHALL clear all latched request fields and old to 0 on reset.

Configuration
REQ-033 SHALL, with CSR_READONLY_TRAP_EN defined, treat any op whose req_addr[11:10]=2'b11 and that would assert csr_wen per REQ-023 as illegal per REQ-028.
REQ-034 SHALL, without CSR_READONLY_TRAP_EN defined, perform such writes normally, with resp_illegal always 0 except for the funct3 cases in REQ-028.

Verification
REQ-035 SHALL cover CSRRW at addr 0x300, rs1_data=0x0000_1888, rd=5, CSR value 0x8 -> csr_ren in cycle T+1, csr_wen with wdata 0x1888 in T+2, resp_data=0x8 with resp_we=1 in T+3.
REQ-036 SHALL cover CSRRS with rs1=0 and CSR value 0x80 -> no csr_wen, resp_data=0x80; then CSRRCI with zimm=0x8 on value 0x88 -> csr_wdata=0x80.
REQ-037 SHALL cover CSRRW with rd=0 -> csr_ren never asserted, csr_wen=1, resp_we=0.
REQ-038 SHALL cover funct3=100 -> resp_valid in cycle T+1 with resp_illegal=1 and no csr strobes; also addr 0xC00 with RW under CSR_READONLY_TRAP_EN -> illegal, and without it -> csr_wen=1.
REQ-039 SHALL cover resp_ready held 0 for 4 cycles -> resp_* outputs stable and req_ready=0 throughout; rst=0 pulsed in WRITE -> csr_wen=0 immediately and state IDLE.

Source files
------------

// File: rtl/csr_unit.sv
// csr_unit: executes one Zicsr instruction at a time (RW/RS/RC and immediate
// forms) against an external CSR file: READ -> WRITE -> RESP.
// Optional feature macro: CSR_READONLY_TRAP_EN. When defined, any op that would
// write a read-only CSR (addr[11:10] == 2'b11) is reported as illegal.
module csr_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_rd,
    output logic            csr_ren,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_we,
    output logic            resp_illegal
);

    localparam int unsigned AW  = 12;
    localparam int unsigned RW5 = 5;
    localparam int unsigned FW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   funct3_q, funct3_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [RW5-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [RW5-1:0]  rd_q, rd_d;
    logic [XLEN-1:0] old_q, old_d;
    logic            illegal_q, illegal_d;

    logic            req_bad_funct3;
    logic            req_would_write;
    logic            req_ro_trap;
    logic            op_is_rw;
    logic            write_en;
    logic [XLEN-1:0] src;
    logic [XLEN-1:0] wr_value;

    // Decode of the offered request; funct3[1:0] == 0 is not a CSR op
    assign req_bad_funct3  = (req_funct3[1:0] == 2'b00);
    assign req_would_write = (req_funct3[1:0] == 2'b01) || (req_rs1 != 5'd0);

`ifdef CSR_READONLY_TRAP_EN
    assign req_ro_trap = req_would_write && (req_addr[11:10] == 2'b11);
`else
    assign req_ro_trap = 1'b0;
`endif

    // Operand selection and write value from the latched instruction
    assign op_is_rw = (funct3_q[1:0] == 2'b01);
    assign write_en = op_is_rw || (rs1_q != 5'd0);
    assign src      = funct3_q[2] ? XLEN'(rs1_q) : rs1_data_q;

    always_comb begin
        wr_value = '0;
        case (funct3_q[1:0])
            2'b01:   wr_value = src;
            2'b10:   wr_value = old_q | src;
            2'b11:   wr_value = old_q & ~src;
            default: wr_value = '0;
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            rs1_q      <= '0;
            rs1_data_q <= '0;
            rd_q       <= '0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            rs1_q      <= rs1_d;
            rs1_data_q <= rs1_data_d;
            rd_q       <= rd_d;
            old_q      <= old_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next-state and output decode; all strobes derive from the state register
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        rs1_d        = rs1_q;
        rs1_data_d   = rs1_data_q;
        rd_d         = rd_q;
        old_d        = old_q;
        illegal_d    = illegal_q;
        req_ready    = 1'b0;
        csr_ren      = 1'b0;
        csr_raddr    = '0;
        csr_wen      = 1'b0;
        csr_waddr    = '0;
        csr_wdata    = '0;
        resp_valid   = 1'b0;
        resp_rd      = '0;
        resp_data    = '0;
        resp_we      = 1'b0;
        resp_illegal = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    rs1_d      = req_rs1;
                    rs1_data_d = req_rs1_data;
                    rd_d       = req_rd;
                    old_d      = '0;
                    illegal_d  = req_bad_funct3 || req_ro_trap;
                    state_d    = (req_bad_funct3 || req_ro_trap) ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                // RW/RWI to x0 must not cause read side effects
                csr_ren   = !(op_is_rw && (rd_q == 5'd0));
                csr_raddr = addr_q;
                old_d     = csr_ren ? csr_rdata : '0;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                csr_wen   = write_en;
                csr_waddr = addr_q;
                csr_wdata = write_en ? wr_value : '0;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid   = 1'b1;
                resp_rd      = rd_q;
                resp_data    = illegal_q ? '0 : old_q;
                resp_we      = !illegal_q && (rd_q != 5'd0);
                resp_illegal = illegal_q;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit. Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point, well away from the next edge.
// Honours CSR_READONLY_TRAP_EN for the read-only-address case.
module tb_csr_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [4:0]  req_rs1;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rd;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_we;
    logic        resp_illegal;

    int total;
    int bad;

    csr_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs1      (req_rs1),
        .req_rs1_data (req_rs1_data),
        .req_rd       (req_rd),
        .csr_ren      (csr_ren),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .csr_wen      (csr_wen),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data),
        .resp_we      (resp_we),
        .resp_illegal (resp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a request in IDLE and advance through the accepting edge
    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                         input logic [31:0] r1d, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_addr     = a;
        req_rs1      = r1;
        req_rs1_data = r1d;
        req_rd       = rd;
        step();
        req_valid    = 1'b0;
    endtask

    // Consume the response and return to IDLE
    task automatic accept_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = 12'd0;
        req_rs1      = 5'd0;
        req_rs1_data = 32'd0;
        req_rd       = 5'd0;
        csr_rdata    = 32'd0;
        resp_ready   = 1'b0;

        // Reset state
        #2;
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_csr_ren",    32'(csr_ren),    32'd0);
        chk("rst_csr_wen",    32'(csr_wen),    32'd0);
        chk("rst_resp_data",  resp_data,       32'd0);
        step();
        rst = 1'b1;
        step();

        // CSRRW 0x300, rs1_data=0x1888, rd=5, CSR holds 0x8
        csr_rdata = 32'h8;
        issue(3'b001, 12'h300, 5'd1, 32'h0000_1888, 5'd5);
        chk("rw_t1_ren",     32'(csr_ren),   32'd1);
        chk("rw_t1_raddr",   32'(csr_raddr), 32'h300);
        chk("rw_t1_ready",   32'(req_ready), 32'd0);
        step();
        chk("rw_t2_wen",     32'(csr_wen),   32'd1);
        chk("rw_t2_waddr",   32'(csr_waddr), 32'h300);
        chk("rw_t2_wdata",   csr_wdata,      32'h1888);
        chk("rw_t2_ren",     32'(csr_ren),   32'd0);
        step();
        chk("rw_t3_valid",   32'(resp_valid),   32'd1);
        chk("rw_t3_data",    resp_data,         32'h8);
        chk("rw_t3_we",      32'(resp_we),      32'd1);
        chk("rw_t3_rd",      32'(resp_rd),      32'd5);
        chk("rw_t3_illegal", 32'(resp_illegal), 32'd0);
        accept_resp();
        chk("rw_idle_ready", 32'(req_ready),  32'd1);
        chk("rw_idle_valid", 32'(resp_valid), 32'd0);

        // CSRRS with rs1=0 on value 0x80: read only
        csr_rdata = 32'h80;
        issue(3'b010, 12'h341, 5'd0, 32'hFFFF_FFFF, 5'd3);
        chk("rs0_ren", 32'(csr_ren), 32'd1);
        step();
        chk("rs0_wen",   32'(csr_wen), 32'd0);
        chk("rs0_wdata", csr_wdata,    32'd0);
        step();
        chk("rs0_data", resp_data,    32'h80);
        chk("rs0_we",   32'(resp_we), 32'd1);
        accept_resp();

        // CSRRCI zimm=8 on value 0x88 -> 0x80
        csr_rdata = 32'h88;
        issue(3'b111, 12'h344, 5'd8, 32'hFFFF_FFFF, 5'd2);
        step();
        chk("rci_wen",   32'(csr_wen), 32'd1);
        chk("rci_wdata", csr_wdata,    32'h80);
        step();
        chk("rci_data", resp_data, 32'h88);
        accept_resp();

        // CSRRW with rd=0: no read, write still happens, no writeback
        csr_rdata = 32'h1234;
        issue(3'b001, 12'h305, 5'd4, 32'hDEAD_BEEF, 5'd0);
        chk("rwx0_ren", 32'(csr_ren), 32'd0);
        step();
        chk("rwx0_wen",   32'(csr_wen), 32'd1);
        chk("rwx0_wdata", csr_wdata,    32'hDEAD_BEEF);
        step();
        chk("rwx0_valid", 32'(resp_valid), 32'd1);
        chk("rwx0_we",    32'(resp_we),    32'd0);
        chk("rwx0_data",  resp_data,       32'd0);
        accept_resp();

        // funct3=100: illegal, response at T+1
        csr_rdata = 32'h77;
        issue(3'b100, 12'h300, 5'd3, 32'h1, 5'd6);
        chk("ill_valid",   32'(resp_valid),   32'd1);
        chk("ill_illegal", 32'(resp_illegal), 32'd1);
        chk("ill_we",      32'(resp_we),      32'd0);
        chk("ill_data",    resp_data,         32'd0);
        chk("ill_ren",     32'(csr_ren),      32'd0);
        chk("ill_wen",     32'(csr_wen),      32'd0);
        accept_resp();

        // RW to read-only address 0xC00
        csr_rdata = 32'h11;
        issue(3'b001, 12'hC00, 5'd9, 32'h55, 5'd1);
`ifdef CSR_READONLY_TRAP_EN
        chk("ro_valid",   32'(resp_valid),   32'd1);
        chk("ro_illegal", 32'(resp_illegal), 32'd1);
        chk("ro_ren",     32'(csr_ren),      32'd0);
        chk("ro_data",    resp_data,         32'd0);
`else
        chk("ro_ren", 32'(csr_ren), 32'd1);
        step();
        chk("ro_wen",   32'(csr_wen), 32'd1);
        chk("ro_wdata", csr_wdata,    32'h55);
        step();
        chk("ro_data",    resp_data,         32'h11);
        chk("ro_illegal", 32'(resp_illegal), 32'd0);
`endif
        accept_resp();

        // CSRRSI zimm=5 on 0xA0, response back-pressured for 4 cycles
        csr_rdata = 32'hA0;
        issue(3'b110, 12'h300, 5'd5, 32'h0, 5'd7);
        step();
        chk("rsi_wdata", csr_wdata, 32'hA5);
        step();
        csr_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data",  resp_data,       32'hA0);
            chk("bp_rd",    32'(resp_rd),    32'd7);
            chk("bp_we",    32'(resp_we),    32'd1);
            chk("bp_ready", 32'(req_ready),  32'd0);
            step();
        end
        chk("bp_valid_end", 32'(resp_valid), 32'd1);
        accept_resp();
        chk("bp_done_ready", 32'(req_ready), 32'd1);

        // Reset pulsed during WRITE aborts the operation
        csr_rdata = 32'h30;
        issue(3'b010, 12'h300, 5'd7, 32'hF, 5'd4);
        step();
        chk("abort_pre_wen", 32'(csr_wen), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_wen",   32'(csr_wen),    32'd0);
        chk("abort_wdata", csr_wdata,       32'd0);
        chk("abort_ready", 32'(req_ready),  32'd1);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
            chk("abort_no_wen",  32'(csr_wen),    32'd0);
            chk("abort_idle",    32'(req_ready),  32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
